// File: rtl/pc_sequencer.sv
// Program-counter sequencer: boots, fetches one instruction at a time,
// holds it for issue, and redirects on branches, jumps and traps.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC   = 32'h00400000,
   parameter logic [31:0] EXC_VECTOR = 32'h80000180
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        fetch_req,
   output logic [31:0] fetch_addr,
   input  logic        fetch_ack,
   input  logic [31:0] fetch_instr,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   input  logic        exception,
   output logic [31:0] epc,
   output logic        misaligned_err,
   output logic [31:0] instr_count
);

   typedef enum logic [1:0] {
      BOOT,
      FETCH,
      ISSUE
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] pc;
   logic        active;
   logic        take_exc;
   logic        take_redir;
   logic        redir_misaligned;

   // Control events are ignored while booting; exception outranks redirect.
   always_comb begin
      active           = (state != BOOT);
      take_exc         = active && exception;
      take_redir       = active && !exception && redirect_valid;
      redir_misaligned = take_redir && (redirect_target[1:0] != 2'b00);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= BOOT;
      else        state <= state_next;
   end

   // Next-state selection.
   always_comb begin
      state_next = state;
      unique case (state)
         BOOT:  state_next = FETCH;
         FETCH: begin
            if (take_exc || take_redir) state_next = FETCH;
            else if (fetch_ack)         state_next = ISSUE;
         end
         ISSUE: begin
            if (take_exc || take_redir) state_next = FETCH;
            else if (!stall)            state_next = FETCH;
         end
         default: state_next = BOOT;
      endcase
   end

   // Fetch and issue handshake outputs decoded from the state.
   always_comb begin
      fetch_req   = (state == FETCH);
      fetch_addr  = pc;
      instr_valid = (state == ISSUE);
   end

   // PC, issued instruction, trap PC and retire counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc             <= RESET_PC;
         instr          <= '0;
         instr_pc       <= '0;
         epc            <= '0;
         instr_count    <= '0;
         misaligned_err <= 1'b0;
      end else begin
         misaligned_err <= 1'b0;
         if (take_exc) begin
            pc  <= EXC_VECTOR;
            epc <= (state == ISSUE) ? instr_pc : pc;
         end else if (redir_misaligned) begin
            // A misaligned target traps; epc records the bad target itself.
            pc             <= EXC_VECTOR;
            epc            <= redirect_target;
            misaligned_err <= 1'b1;
         end else if (take_redir) begin
            pc <= redirect_target;
         end else if (state == FETCH) begin
            if (fetch_ack) begin
               instr    <= fetch_instr;
               instr_pc <= pc;
            end
         end else if (state == ISSUE) begin
            if (!stall) begin
               pc          <= pc + 32'd4;
               instr_count <= instr_count + 32'd1;
            end
         end
      end
   end

endmodule
